imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Registered, parametrised successor to the combinational immediate generator. It sits between decode and execute: it accepts the upper instruction bits (instr[31:7]) with an immediate selector and a side-band tag (PC), then emits the sign/zero-extended immediate one cycle later. It uses a valid/ready handshake with an optional skid buffer and a flush input. It supports RV32 and RV64 widths and adds shamt, CSR-zimm and a reserved-selector error flag.

Parameters:
IMMWIDTH, 25, input field width; bit k equals instr[k+7].
DWIDTH, 32, immediate width; legal values are 32 or 64.
TAGW, 32, width of the side-band tag carried alongside each immediate.
SKID, 1, 1 gives a 2-entry skid buffer with registered in_ready; 0 gives a single register with combinational in_ready.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous active-low reset.
flush  in  1  drop all held and incoming entries.
in_valid  in  1  upstream entry valid.
in_ready  out  1  block can accept an entry this cycle.
in_bits  in  IMMWIDTH  instr[31:7].
imm_sel  in  4  [2:0] selects the format; [3] selects signed for the I format only.
tag_in  in  TAGW  side-band data, passed through unchanged.
out_valid  out  1  output entry valid.
out_ready  in  1  downstream accepts the output entry.
imm_out  out  DWIDTH  extended immediate.
tag_out  out  TAGW  tag matching imm_out.
imm_err  out  1  entry had a reserved selector or an illegal shamt.

Behaviour:
- Reset (rst_n=0 at a clock edge) sets: out_valid=0, imm_out=0, tag_out=0, imm_err=0, skid empty. in_ready=1 in the first cycle after reset. Reset overrides flush and all handshakes.
- Formats, where s = in_bits[24] is replicated to DWIDTH:
  - 000 I: {s or 0, in[24:13]}; sign-extend if imm_sel[3]=1, else zero-extend.
  - 001 S: {s, in[24:18], in[4:0]}.
  - 010 B: {s, in[0], in[23:18], in[4:1], 0}.
  - 011 U: {s for DWIDTH-32 bits, in[24:5], 12'b0}; the upper 32 bits are sign-filled on RV64.
  - 100 J: {s, in[12:5], in[13], in[23:14], 0}.
  - 101 shamt: zero-extended in[18:13] when DWIDTH=64, in[17:13] when DWIDTH=32. On DWIDTH=32, in[18]=1 sets imm_err and the shamt value is still output.
  - 110 zimm: zero-extended in[12:8].
  - 111 reserved: imm=0 and imm_err=1.
- imm_sel[3] is ignored for every format except 000.
- Transfer: an entry is accepted when in_valid&&in_ready and is presented on out_valid/imm_out the next cycle (latency 1). It leaves when out_valid&&out_ready.
- Stability: while out_valid=1 and out_ready=0, imm_out, tag_out and imm_err hold constant.
- SKID=1 states:
  - EMPTY (in_ready=1, out_valid=0): accept → FULL.
  - FULL (in_ready=1, out_valid=1):
    - accept with out_ready=1 → FULL, new data.
    - accept with out_ready=0 → SKID, new entry in skid register.
    - no accept with out_ready=1 → EMPTY.
  - SKID (in_ready=0, out_valid=1): out_ready=1 moves the skid entry to output → FULL.
  - in_ready is a flop output, !skid_valid.
- SKID=0: in_ready = !out_valid || out_ready. Simultaneous pop and push in the same cycle sustains 1 entry/cycle.
- Ordering: strict FIFO. No entry is lost or duplicated.
- Flush: at the clock edge, all valid bits clear and an entry offered in the same cycle is dropped. Next cycle out_valid=0 and in_ready=1. Data registers may retain stale values.
- Data registers load only on accept or skid transfer.

Decomposition:
- Package imm_pkg holds:
  - localparams IMM_I=3'b000, IMM_S=3'b001, IMM_B=3'b010, IMM_U=3'b011, IMM_J=3'b100, IMM_SH=3'b101, IMM_Z=3'b110, IMM_RSV=3'b111;
  - the SIGNED bit index 3;
  - the skid state encoding EMPTY/FULL/SKID.
- One combinational sub-module, imm_decode (in_bits, imm_sel → imm, err), parametrised by DWIDTH. The top owns the handshake and skid registers.

Test Plan:
1. in_bits=0x1FFE001 (addi -1): imm_sel=4'b1000 → imm_out=0xFFFFFFFF one cycle after accept; imm_sel=4'b0000 → 0x00000FFF; imm_err=0.
2. Formats at DWIDTH=32:
   - B from instr 0x00000463 → 0x00000008.
   - J from 0xFFDFF06F → 0xFFFFFFFC.
   - U from 0x123450B7 → 0x12345000.
   - DWIDTH=64, U from 0x800000B7 → 0xFFFFFFFF80000000.
3. Back-to-back tags 1,2,3 with out_ready=0 for 3 cycles (SKID=1): in_ready drops after tag 2 and tag 3 is held upstream. Releasing out_ready yields tags 1,2,3 in order on consecutive cycles, with imm_out stable while stalled.
4. Flush while in state SKID, with in_valid=1 on the same cycle: next cycle out_valid=0 and in_ready=1, and no flushed tag ever appears.
5. imm_sel=3'b111 → imm_out=0, imm_err=1. Shamt with in[18]=1 at DWIDTH=32 → imm_err=1; the same entry at DWIDTH=64 → imm_out=0x20|in[17:13], imm_err=0.
6. rst_n=0 mid-stall with flush=1: next cycle all outputs are 0 and in_ready=1. A random valid/ready stream compared against a reference decode model shows no loss.

Source files
------------

// File: rtl/imm_gen_pipe_pkg.sv
// Shared immediate-format selectors and pipeline state encoding for imm_gen_pipe.
// Selector values mirror the funct-style encoding driven by decode.
package imm_pkg;

  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_S   = 3'b001;
  localparam logic [2:0] IMM_B   = 3'b010;
  localparam logic [2:0] IMM_U   = 3'b011;
  localparam logic [2:0] IMM_J   = 3'b100;
  localparam logic [2:0] IMM_SH  = 3'b101;
  localparam logic [2:0] IMM_Z   = 3'b110;
  localparam logic [2:0] IMM_RSV = 3'b111;

  localparam int SIGNED_BIT = 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational immediate extraction from instr[31:7]; zero latency, no flow control.
// err flags the reserved selector and, on RV32, a shamt with bit 5 set.
module imm_decode
  import imm_pkg::*;
#(
  parameter int IMMWIDTH = 25,
  parameter int DWIDTH   = 32
) (
  input  logic [IMMWIDTH-1:0] in_bits,
  input  logic [3:0]          imm_sel,
  output logic [DWIDTH-1:0]   imm,
  output logic                err
);

  logic              s;
  logic [DWIDTH-1:0] u_imm;

  assign s = in_bits[24];

  // U only needs an upper sign fill on RV64; RV32 has no room for it
  generate
    if (DWIDTH == 64) begin : g_u64
      assign u_imm = {{32{s}}, in_bits[24:5], 12'h000};
    end else begin : g_u32
      assign u_imm = {in_bits[24:5], 12'h000};
    end
  endgenerate

  always_comb begin
    imm = '0;
    err = 1'b0;
    case (imm_sel[2:0])
      IMM_I:   imm = {{(DWIDTH-12){s & imm_sel[SIGNED_BIT]}}, in_bits[24:13]};
      IMM_S:   imm = {{(DWIDTH-12){s}}, in_bits[24:18], in_bits[4:0]};
      IMM_B:   imm = {{(DWIDTH-12){s}}, in_bits[0], in_bits[23:18], in_bits[4:1], 1'b0};
      IMM_U:   imm = u_imm;
      IMM_J:   imm = {{(DWIDTH-20){s}}, in_bits[12:5], in_bits[13], in_bits[23:14], 1'b0};
      IMM_SH: begin
        if (DWIDTH == 64) begin
          imm = {{(DWIDTH-6){1'b0}}, in_bits[18:13]};
        end else begin
          imm = {{(DWIDTH-5){1'b0}}, in_bits[17:13]};
          err = in_bits[18];
        end
      end
      IMM_Z:   imm = {{(DWIDTH-5){1'b0}}, in_bits[12:8]};
      IMM_RSV: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator between decode and execute; 1-cycle latency.
// SKID=1: 2-entry skid with registered in_ready; SKID=0: single stage, in_ready = !out_valid || out_ready.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int IMMWIDTH = 25,
  parameter int DWIDTH   = 32,
  parameter int TAGW     = 32,
  parameter int SKID     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IMMWIDTH-1:0] in_bits,
  input  logic [3:0]          imm_sel,
  input  logic [TAGW-1:0]     tag_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DWIDTH-1:0]   imm_out,
  output logic [TAGW-1:0]     tag_out,
  output logic                imm_err
);

  logic [DWIDTH-1:0] dec_imm;
  logic              dec_err;
  skid_state_e       state;
  logic              vld_q;
  logic              rdy_q;
  logic              accept;
  logic              to_skid;
  logic [DWIDTH-1:0] skid_imm;
  logic [TAGW-1:0]   skid_tag;
  logic              skid_err;

  imm_decode #(
    .IMMWIDTH (IMMWIDTH),
    .DWIDTH   (DWIDTH)
  ) u_decode (
    .in_bits (in_bits),
    .imm_sel (imm_sel),
    .imm     (dec_imm),
    .err     (dec_err)
  );

  assign out_valid = vld_q;
  assign in_ready  = (SKID != 0) ? rdy_q : (!vld_q || out_ready);
  assign accept    = in_valid && in_ready;
  // Only reachable with SKID=1: with SKID=0 in_ready is low whenever this holds
  assign to_skid   = (state == ST_FULL) && accept && !out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_EMPTY;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
      imm_out <= '0;
      tag_out <= '0;
      imm_err <= 1'b0;
    end else if (flush) begin
      state <= ST_EMPTY;
      vld_q <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            imm_out <= dec_imm;
            tag_out <= tag_in;
            imm_err <= dec_err;
            state   <= ST_FULL;
            vld_q   <= 1'b1;
          end
        end
        ST_FULL: begin
          if (accept && out_ready) begin
            imm_out <= dec_imm;
            tag_out <= tag_in;
            imm_err <= dec_err;
          end else if (accept) begin
            state <= ST_SKID;
            rdy_q <= 1'b0;
          end else if (out_ready) begin
            state <= ST_EMPTY;
            vld_q <= 1'b0;
          end
        end
        ST_SKID: begin
          if (out_ready) begin
            imm_out <= skid_imm;
            tag_out <= skid_tag;
            imm_err <= skid_err;
            state   <= ST_FULL;
            rdy_q   <= 1'b1;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  // Skid data needs no reset: it is only read once the state says it is valid
  always_ff @(posedge clk) begin
    if (to_skid) begin
      skid_imm <= dec_imm;
      skid_tag <= tag_in;
      skid_err <= dec_err;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed and random checks of imm_gen_pipe: dut 0 is RV32 with skid, dut 1 is RV64 single-stage.
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic        err;
    logic [31:0] tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [24:0] in_bits   [2];
  logic [3:0]  imm_sel   [2];
  logic [31:0] tag_in    [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] tag_out   [2];
  logic        imm_err   [2];
  logic [31:0] imm32;
  logic [63:0] imm64;

  int total  = 0;
  int passed = 0;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.IMMWIDTH(25), .DWIDTH(32), .TAGW(32), .SKID(1)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_bits(in_bits[0]),
    .imm_sel(imm_sel[0]), .tag_in(tag_in[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .imm_out(imm32), .tag_out(tag_out[0]), .imm_err(imm_err[0])
  );

  imm_gen_pipe #(.IMMWIDTH(25), .DWIDTH(64), .TAGW(32), .SKID(0)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_bits(in_bits[1]),
    .imm_sel(imm_sel[1]), .tag_in(tag_in[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .imm_out(imm64), .tag_out(tag_out[1]), .imm_err(imm_err[1])
  );

  function automatic logic [63:0] get_imm(input int d);
    return (d == 0) ? {32'h0, imm32} : imm64;
  endfunction

  // Reference built from the full 32-bit instruction, as the ISA manual states the formats
  function automatic logic [64:0] model(input logic [24:0] b, input logic [3:0] sel, input int dw);
    logic [31:0]        ins;
    logic signed [63:0] x, t20, t25, t31;
    logic [63:0]        r;
    logic               e;
    ins = {b, 7'h00};
    x   = {{32{ins[31]}}, ins};
    t20 = x >>> 20;
    t25 = x >>> 25;
    t31 = x >>> 31;
    r   = '0;
    e   = 1'b0;
    case (sel[2:0])
      3'd0: r = sel[3] ? t20 : {52'h0, ins[31:20]};
      3'd1: r = (t25 << 5) | {59'h0, ins[11:7]};
      3'd2: r = (t31 << 12) | {52'h0, ins[7], ins[30:25], ins[11:8], 1'b0};
      3'd3: r = x & ~64'hFFF;
      3'd4: r = (t31 << 20) | {44'h0, ins[19:12], ins[20], ins[30:21], 1'b0};
      3'd5: begin
        if (dw == 64) r = {58'h0, ins[25:20]};
        else begin
          r = {59'h0, ins[24:20]};
          e = ins[25];
        end
      end
      3'd6: r = {59'h0, ins[19:15]};
      default: e = 1'b1;
    endcase
    if (dw == 32) r[63:32] = '0;
    return {e, r};
  endfunction

  task automatic set_in(input int d, input logic v, input logic [24:0] b,
                        input logic [3:0] s, input logic [31:0] t);
    in_valid[d] = v;
    in_bits[d]  = b;
    imm_sel[d]  = s;
    tag_in[d]   = t;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    for (int d = 0; d < 2; d++) begin
      set_in(d, 1'b0, '0, '0, '0);
      out_ready[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({out_valid[d], in_ready[d], imm_err[d], tag_out[d], get_imm(d)} !== {1'b0, 1'b1, 1'b0, 32'h0, 64'h0})
        $display("FAIL reset dut%0d: got v=%b rdy=%b err=%b tag=%h imm=%h, expected v=0 rdy=1 err=0 tag=0 imm=0",
                 d, out_valid[d], in_ready[d], imm_err[d], tag_out[d], get_imm(d));
      else passed++;
    end
  endtask

  task automatic test_one(input string name, input logic [24:0] b, input logic [3:0] s,
                          input logic [31:0] t, input logic [63:0] e32, input logic [63:0] e64,
                          input logic err32, input logic err64);
    logic [97:0] obs, exp;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      out_ready[d] = 1'b1;
      set_in(d, 1'b1, b, s, t);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) in_valid[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      obs = {out_valid[d], imm_err[d], tag_out[d], get_imm(d)};
      exp = {1'b1, (d == 0) ? err32 : err64, t, (d == 0) ? e32 : e64};
      total++;
      if (obs !== exp)
        $display("FAIL %s dut%0d: got {v,err,tag,imm}=%h expected %h", name, d, obs, exp);
      else passed++;
    end
  endtask

  task automatic test_formats();
    test_one("addi_signed",   25'h1FFE001, 4'b1000, 32'h101, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    test_one("addi_unsigned", 25'h1FFE001, 4'b0000, 32'h102, 64'h0000_0FFF, 64'h0000_0FFF, 1'b0, 1'b0);
    test_one("b_format",      25'h0000008, 4'b0010, 32'h103, 64'h8, 64'h8, 1'b0, 1'b0);
    test_one("j_format",      25'h1FFBFE0, 4'b0100, 32'h104, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
    test_one("u_format",      25'h02468A1, 4'b0011, 32'h105, 64'h1234_5000, 64'h1234_5000, 1'b0, 1'b0);
    test_one("u_negative",    25'h1000001, 4'b0011, 32'h106, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0);
    test_one("s_sel3_ignored",25'h1FC001C, 4'b1001, 32'h107, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
    test_one("zimm",          25'h0001500, 4'b1110, 32'h108, 64'h15, 64'h15, 1'b0, 1'b0);
    test_one("reserved",      25'h1FFFFFF, 4'b0111, 32'h109, 64'h0, 64'h0, 1'b1, 1'b1);
    test_one("shamt_bit5",    25'h0046000, 4'b0101, 32'h10A, 64'h3, 64'h23, 1'b1, 1'b0);
    test_one("shamt_legal",   25'h003E000, 4'b0101, 32'h10B, 64'h1F, 64'h1F, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] got [$];
    int          cyc [$];
    logic        acc;
    @(posedge clk);
    #1;
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b1;
    out_ready[0] = 1'b0;
    set_in(0, 1'b1, 25'(1) << 13, 4'b0000, 32'd1);
    @(posedge clk);
    #1 set_in(0, 1'b1, 25'(2) << 13, 4'b0000, 32'd2);
    @(posedge clk);
    #1 set_in(0, 1'b1, 25'(3) << 13, 4'b0000, 32'd3);
    repeat (2) begin
      @(negedge clk);
      total++;
      if ({in_ready[0], out_valid[0], tag_out[0], imm32} !== {1'b0, 1'b1, 32'd1, 32'd1})
        $display("FAIL stall_hold: got rdy=%b v=%b tag=%h imm=%h, expected rdy=0 v=1 tag=1 imm=1",
                 in_ready[0], out_valid[0], tag_out[0], imm32);
      else passed++;
    end
    @(posedge clk);
    #1 out_ready[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid[0] && out_ready[0]) begin
        got.push_back(tag_out[0]);
        cyc.push_back(c);
        total++;
        if (imm32 !== tag_out[0])
          $display("FAIL drain_imm: got imm=%h for tag %h, expected imm equal to tag", imm32, tag_out[0]);
        else passed++;
      end
      acc = in_valid[0] && in_ready[0];
      @(posedge clk);
      #1 if (acc) in_valid[0] = 1'b0;
    end
    total++;
    if (got.size() != 3 || got[0] !== 32'd1 || got[1] !== 32'd2 || got[2] !== 32'd3 || cyc[2] - cyc[0] != 2)
      $display("FAIL drain_order: got %0d tags %p at cycles %p, expected tags 1,2,3 on consecutive cycles",
               got.size(), got, cyc);
    else passed++;
  endtask

  task automatic test_flush();
    logic seen;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    set_in(0, 1'b1, 25'h0, 4'b0000, 32'h10);
    @(posedge clk);
    #1 set_in(0, 1'b1, 25'h0, 4'b0000, 32'h11);
    @(posedge clk);
    #1;
    flush = 1'b1;
    set_in(0, 1'b1, 25'h0, 4'b0000, 32'h12);
    @(posedge clk);
    #1;
    flush       = 1'b0;
    in_valid[0] = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid[0], in_ready[0]} !== 2'b01)
      $display("FAIL flush_state: got v=%b rdy=%b, expected v=0 rdy=1", out_valid[0], in_ready[0]);
    else passed++;
    out_ready[0] = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid[0]) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0)
      $display("FAIL flush_leak: got a flushed entry on the output, expected none");
    else passed++;
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    out_ready[1] = 1'b0;
    set_in(0, 1'b1, 25'h1FFFFFF, 4'b0111, 32'h20);
    set_in(1, 1'b1, 25'h1FFFFFF, 4'b0111, 32'h30);
    @(posedge clk);
    #1;
    set_in(0, 1'b1, 25'h1FFFFFF, 4'b1000, 32'h21);
    in_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    set_in(0, 1'b1, 25'h1FFFFFF, 4'b1000, 32'h22);
    rst_n = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    flush       = 1'b0;
    in_valid[0] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({out_valid[d], in_ready[d], imm_err[d], tag_out[d], get_imm(d)} !== {1'b0, 1'b1, 1'b0, 32'h0, 64'h0})
        $display("FAIL reset_mid dut%0d: got v=%b rdy=%b err=%b tag=%h imm=%h, expected v=0 rdy=1 err=0 tag=0 imm=0",
                 d, out_valid[d], in_ready[d], imm_err[d], tag_out[d], get_imm(d));
      else passed++;
    end
  endtask

  task automatic test_random();
    localparam int N = 400;
    logic        acc [2];
    logic [64:0] m;
    exp_t        e;
    logic        empty;
    int          next_tag;
    next_tag = 32'h1000;
    acc[0]   = 1'b0;
    acc[1]   = 1'b0;
    for (int c = 0; c < N + 12; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (out_valid[d] && out_ready[d]) begin
          empty = 1'b0;
          e     = '0;
          if (d == 0) begin
            if (q0.size() > 0) e = q0.pop_front(); else empty = 1'b1;
          end else begin
            if (q1.size() > 0) e = q1.pop_front(); else empty = 1'b1;
          end
          total++;
          if (empty || {imm_err[d], tag_out[d], get_imm(d)} !== {e.err, e.tag, e.imm})
            $display("FAIL stream dut%0d: got err=%b tag=%h imm=%h, expected err=%b tag=%h imm=%h (queue empty=%b)",
                     d, imm_err[d], tag_out[d], get_imm(d), e.err, e.tag, e.imm, empty);
          else passed++;
        end
        acc[d] = in_valid[d] && in_ready[d];
        if (acc[d]) begin
          m = model(in_bits[d], imm_sel[d], (d == 0) ? 32 : 64);
          e = '{imm: m[63:0], err: m[64], tag: tag_in[d]};
          if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (c < N) begin
          if (acc[d] || !in_valid[d]) begin
            set_in(d, ($urandom_range(0, 3) != 0), 25'($urandom), 4'($urandom_range(0, 15)), next_tag);
            next_tag++;
          end
          out_ready[d] = ($urandom_range(0, 3) != 0);
        end else begin
          in_valid[d]  = 1'b0;
          out_ready[d] = 1'b1;
        end
      end
    end
    total++;
    if (q0.size() != 0 || q1.size() != 0)
      $display("FAIL stream_drain: got %0d/%0d entries never delivered, expected 0/0", q0.size(), q1.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_formats();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
